// File: rtl/gf163_pkg.sv
// Purpose : shared constants, FSM state type and overflow fold for the GF(2^163) multiplier.
// Latency : n/a (package, combinational helper only).
// Backpr. : n/a.
// Field polynomial f(x) = x^163 + x^7 + x^6 + x^3 + 1.
package gf163_pkg;

    localparam int M    = 163;
    // Widest digit supported; the fold below is sized for it.
    localparam int DMAX = 16;

    // Low-order terms of f(x): x^163 == x^7 + x^6 + x^3 + 1 (mod f).
    localparam logic [M-1:0] F_TAIL = 163'hC9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Reduce a polynomial of degree < M+DMAX. The overflow h above bit 162
    // is multiplied by the tail. The result has degree <= DMAX-1+7 < M, so
    // one fold is exact.
    function automatic logic [M-1:0] gf_fold(input logic [M+DMAX-1:0] v);
        logic [DMAX-1:0] h;
        logic [M-1:0]    r;
        h = v[M+DMAX-1:M];
        r = v[M-1:0];
        for (int j = 0; j < 8; j++) begin
            if (F_TAIL[j]) begin
                r = r ^ (M'(h) << j);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/gf163_mul_ctrl_if.sv
// Purpose : operand/result handshake bundle for gf163_mul_ctrl.
// Latency : n/a (wires only).
// Backpr. : in_* by in_ready, out_* by out_ready (valid/ready on both sides).
// Ports   : in_valid/in_ready/in_a/in_b operand side, out_valid/out_ready/out_c result side.
interface gf163_mul_ctrl_if;

    logic         in_valid;
    logic         in_ready;
    logic [162:0] in_a;
    logic [162:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [162:0] out_c;

    // Multiplier side.
    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_c
    );

    // Scheduler / register-file side.
    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_c
    );

endinterface

// File: rtl/gf163_digit_step.sv
// Purpose : one digit-serial step, acc_o = (acc_i*x^DIGIT + d_i*b_i) mod f.
// Latency : purely combinational.
// Backpr. : none.
// Ports   : acc_i reduced accumulator, b_i multiplicand, d_i multiplier digit, acc_o next accumulator.
module gf163_digit_step
    import gf163_pkg::*;
#(
    parameter int DIGIT = 8
) (
    input  logic [M-1:0]     acc_i,
    input  logic [M-1:0]     b_i,
    input  logic [DIGIT-1:0] d_i,
    output logic [M-1:0]     acc_o
);

    logic [M+DMAX-1:0] shifted;
    logic [M+DMAX-1:0] pprod;

    always_comb begin
        shifted = (M+DMAX)'(acc_i) << DIGIT;
        pprod   = '0;
        for (int i = 0; i < DIGIT; i++) begin
            if (d_i[i]) begin
                pprod = pprod ^ ((M+DMAX)'(b_i) << i);
            end
        end
        // The fold is linear, so both terms are reduced in a single pass.
        acc_o = gf_fold(shifted ^ pprod);
    end

endmodule

// File: rtl/gf163_mul_ctrl.sv
// Purpose : digit-serial GF(2^163) multiplier with sequencer (optional abort: GF163_MUL_ABORT_EN).
// Latency : out_valid rises N = ceil(163/DIGIT) cycles after acceptance; II = N+2.
// Backpr. : accepts only in IDLE; DONE holds out_c stable until out_ready.
// Ports   : clk, rst (sync active-high), abort (macro only), bus (slave modport of gf163_mul_ctrl_if).
module gf163_mul_ctrl
    import gf163_pkg::*;
#(
    parameter int DIGIT = 8
) (
    input  logic           clk,
    input  logic           rst,
`ifdef GF163_MUL_ABORT_EN
    input  logic           abort,
`endif
    gf163_mul_ctrl_if.slave bus
);

    localparam int N  = (M + DIGIT - 1) / DIGIT;
    localparam int AW = N * DIGIT;
    localparam int CW = $clog2(N);

    state_t          state_q;
    logic [AW-1:0]   a_q;
    logic [M-1:0]    b_q;
    logic [M-1:0]    acc_q;
    logic [M-1:0]    acc_d;
    logic [CW-1:0]   cnt_q;
    logic            out_valid_q;
    logic [M-1:0]    out_c_q;
    logic [DIGIT-1:0] digit;
    logic            abort_w;

`ifdef GF163_MUL_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // a_q is the zero-padded multiplier, shifted left one digit per step, so
    // the top digit is always the next one to consume (MSB-first).
    assign digit = a_q[AW-1 -: DIGIT];

    gf163_digit_step #(
        .DIGIT (DIGIT)
    ) u_step (
        .acc_i (acc_q),
        .b_i   (b_q),
        .d_i   (digit),
        .acc_o (acc_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_c_q     <= '0;
        end else if (abort_w && (state_q != IDLE)) begin
            // out_c keeps its last value; only the handshake is dropped.
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= AW'(bus.in_a);
                        b_q     <= bus.in_b;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    a_q   <= a_q << DIGIT;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(N - 1)) begin
                        out_c_q     <= acc_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Decoded from state only; no combinational path from in_valid.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_c     = out_c_q;

endmodule
